// File: rtl/regfile_mp.sv
// regfile_mp: dual-write register bank with write-to-read bypass and busy scoreboard
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ReadAddr1,
  input  logic [ADDR_W-1:0] ReadAddr2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              ReadBusy1,
  output logic              ReadBusy2,
  input  logic              RegWrite0,
  input  logic              RegWrite1,
  input  logic [ADDR_W-1:0] WriteAddr0,
  input  logic [ADDR_W-1:0] WriteAddr1,
  input  logic [DATA_W-1:0] WriteData0,
  input  logic [DATA_W-1:0] WriteData1,
  input  logic              Reserve,
  input  logic [ADDR_W-1:0] ReserveAddr,
  output logic              WriteConflict
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy, busy_nxt;
  logic act0, act1, we0, we1, rsv, conflict;
  logic z1, z2, hit1_0, hit1_1, hit2_0, hit2_1;
  // Bypass is gated by reset so outputs show the zeroed state while held in reset.
  assign act0 = RegWrite0 && reset;
  assign act1 = RegWrite1 && reset;
  assign we0 = act0 && !(ZERO_REG != 0 && WriteAddr0 == '0);
  assign we1 = act1 && !(ZERO_REG != 0 && WriteAddr1 == '0);
  assign rsv = Reserve && !(ZERO_REG != 0 && ReserveAddr == '0);
  assign conflict = we0 && we1 && WriteAddr0 == WriteAddr1;
  assign z1 = ZERO_REG != 0 && ReadAddr1 == '0;
  assign z2 = ZERO_REG != 0 && ReadAddr2 == '0;
  assign hit1_0 = act0 && WriteAddr0 == ReadAddr1;
  assign hit1_1 = act1 && WriteAddr1 == ReadAddr1;
  assign hit2_0 = act0 && WriteAddr0 == ReadAddr2;
  assign hit2_1 = act1 && WriteAddr1 == ReadAddr2;
  assign ReadData1 = z1 ? '0 : hit1_1 ? WriteData1 : hit1_0 ? WriteData0 : regs[ReadAddr1];
  assign ReadData2 = z2 ? '0 : hit2_1 ? WriteData1 : hit2_0 ? WriteData0 : regs[ReadAddr2];
  assign ReadBusy1 = busy[ReadAddr1] && !hit1_0 && !hit1_1 && !z1;
  assign ReadBusy2 = busy[ReadAddr2] && !hit2_0 && !hit2_1 && !z2;
  // A new reservation supersedes a retiring write to the same register.
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < DEPTH; i++)
      busy_nxt[i] = (busy[i] && !(we0 && WriteAddr0 == ADDR_W'(i)) && !(we1 && WriteAddr1 == ADDR_W'(i)))
                    || (rsv && ReserveAddr == ADDR_W'(i));
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      regs <= '{default: '0};
      busy <= '0;
      WriteConflict <= 1'b0;
    end else begin
      if (we0) regs[WriteAddr0] <= WriteData0;
      if (we1) regs[WriteAddr1] <= WriteData1;
      busy <= busy_nxt;
      if (conflict) WriteConflict <= 1'b1;
    end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register bank, the next generation of the CPU register file. It adds a second write port, same-cycle write-to-read bypass and a per-register busy scoreboard for hazard detection. It sits between decode (reads, reservations) and writeback (two retire ports: ALU and load), and removes the one-cycle write/read bubble in the 2VA datapath.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- ZERO_REG, 1, 1 = register 0 hardwired to zero; 0 = register 0 is an ordinary register
- clock  in  1  rising-edge clock; the only clock
- reset  in  1  asynchronous, active-low reset
- ReadAddr1, ReadAddr2  in  ADDR_W  read port addresses
- ReadData1, ReadData2  out  DATA_W  read data, combinational
- ReadBusy1, ReadBusy2  out  1  addressed register has an outstanding reservation not satisfied this cycle
- RegWrite0, RegWrite1  in  1  write enables (port 0 = ALU, port 1 = load)
- WriteAddr0, WriteAddr1  in  ADDR_W  write addresses
- WriteData0, WriteData1  in  DATA_W  write data
- Reserve  in  1  mark ReserveAddr busy (pending producer issued)
- ReserveAddr  in  ADDR_W  register to reserve
- WriteConflict  out  1  sticky: both write ports hit the same register in one cycle

## Operation
- Storage: 2**ADDR_W x DATA_W registers plus 2**ADDR_W busy bits plus the WriteConflict flag.
- Reset (reset low, asynchronous): all registers 0, all busy bits 0, WriteConflict 0. While reset is low, writes and reservations are ignored; outputs reflect the zeroed state.
- Write: on posedge, for each port with RegWrite set, the register at WriteAddr takes WriteData.
  - Both ports enabled with the same address: port 1 wins and WriteConflict sets; it stays set until reset.
  - With ZERO_REG=1, a write to address 0 is dropped silently, clears nothing, and never sets WriteConflict.
- Read: ReadDataN uses this priority:
  - 0 when ZERO_REG=1 and ReadAddrN==0;
  - else WriteData1 if RegWrite1 && WriteAddr1==ReadAddrN;
  - else WriteData0 if RegWrite0 && WriteAddr0==ReadAddrN;
  - else the stored value.
- Scoreboard:
  - On posedge, a write (either port) to address A clears busy[A].
  - Reserve sets busy[ReserveAddr].
  - Reserve and write to the same address in one cycle: the address ends busy, because reserve wins (a new producer supersedes the retiring one).
  - A reservation of address 0 with ZERO_REG=1 is ignored.
  - Reserving an already-busy register leaves it busy; there is no count, and the latest producer clears it.
- ReadBusyN = busy[ReadAddrN] && no enabled write port targets ReadAddrN this cycle. This output is 0 for address 0 when ZERO_REG=1.

## Timing
- Read path is combinational: zero-cycle latency from ReadAddr and write inputs to ReadData and ReadBusy.
- Write latency: data is visible the same cycle through bypass, and from the stored array starting the cycle after the posedge.
- Busy set by Reserve at posedge T is visible on ReadBusy from T onward.
- WriteConflict asserts in the cycle after the colliding posedge.
- Reset deassertion is not synchronised internally; the system guarantees deassertion away from clock edges.

## Test plan
- Reset: write 0xDEADBEEF to r5, pulse reset low mid-cycle -> ReadData1 for r5 = 0 immediately, busy bits cleared, WriteConflict = 0.
- Bypass: RegWrite0, r7 <- 0x12345678 with ReadAddr1=7 in the same cycle -> ReadData1 = 0x12345678 before the edge and after it with writes idle.
- Dual-write collision: port 0 r3 <- 0x11, port 1 r3 <- 0x22 -> r3 = 0x22, WriteConflict = 1 and sticky for 10 idle cycles. Repeating with address 0 -> no flag, r0 reads 0.
- Scoreboard:
  - Reserve r9 -> ReadBusy2 = 1 on r9 until port 1 writes r9, then 0.
  - In the writeback cycle, ReadBusy2 = 0 with bypassed data.
- Reserve/write race: Reserve r4 while port 0 writes r4 -> r4 holds the new data and ReadBusy1 on r4 = 1 next cycle.
- Parameters: DATA_W=16, ADDR_W=3, ZERO_REG=0 -> r0 writable (r0 <- 0xBEEF reads back); addresses 0-7 all independent.
